// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared defaults, read FSM states and grant type for the UART FIFO scheduler
package uart_fifo_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int RD_LAT_DEF = 2;
  localparam int CW_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_REQ0 = 2'b01,
    GNT_REQ1 = 2'b10
  } grant_t;

endpackage

// File: rtl/uart_fifo_rr_arb.sv
// rtl/uart_fifo_rr_arb.sv - two-way round-robin write arbiter qualified by FIFO space
module uart_fifo_rr_arb
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0_valid,
  input  logic          req1_valid,
  input  logic [CW-1:0] level,
  input  logic          wr_pending,
  output grant_t        gnt
);

  logic        prio_q, prio_d;
  logic [CW:0] occ;
  logic        space;

  // prio_q set means req1 wins the next contested grant
  always_comb begin
    occ    = {1'b0, level} + {{CW{1'b0}}, wr_pending};
    space  = occ < (CW+1)'(DEPTH - 1);
    gnt    = GNT_NONE;
    prio_d = prio_q;
    if (space) begin
      if (req0_valid && req1_valid) begin
        gnt    = prio_q ? GNT_REQ1 : GNT_REQ0;
        prio_d = ~prio_q;
      end else if (req0_valid) begin
        gnt = GNT_REQ0;
      end else if (req1_valid) begin
        gnt = GNT_REQ1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/uart_fifo_sched.sv
// rtl/uart_fifo_sched.sv - FIFO write arbiter, read sequencer and level tracker
// Optional level interrupt built only when UART_FIFO_SCHED_IRQ_EN is defined.
module uart_fifo_sched
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0_valid,
  input  logic [7:0]    req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_data,
  output logic          req1_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          WRB,
  output logic          RDB,
  output logic [7:0]    fifo_wdata,
  input  logic [7:0]    fifo_rdata,
  output logic [CW-1:0] level,
  input  logic [CW-1:0] thresh,
  output logic          irq
);

  localparam int WCW = $clog2(RD_LAT) + 1;

  grant_t          gnt;
  logic            wr_pending;
  logic            wrb_q, wrb_d;
  logic            rdb_q, rdb_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [CW-1:0]   level_q, level_d;
  rd_state_t       state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            inc, dec;

  assign wr_pending = ~wrb_q;

  uart_fifo_rr_arb #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_arb (
    .CLK        (CLK),
    .RESET      (RESET),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .level      (level_q),
    .wr_pending (wr_pending),
    .gnt        (gnt)
  );

  always_comb begin
    wrb_d   = 1'b1;
    wdata_d = wdata_q;
    case (gnt)
      GNT_REQ0: begin
        wrb_d   = 1'b0;
        wdata_d = req0_data;
      end
      GNT_REQ1: begin
        wrb_d   = 1'b0;
        wdata_d = req1_data;
      end
      default: ;
    endcase
  end

  // Strobes count on the cycle they are low, so level trails a grant by two cycles
  always_comb begin
    inc     = ~wrb_q;
    dec     = ~rdb_q;
    level_d = level_q;
    if (inc && !dec) begin
      level_d = level_q + CW'(1);
    end else if (dec && !inc) begin
      level_d = level_q - CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    rdb_d      = 1'b1;
    wait_cnt_d = wait_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d = ISSUE;
          rdb_d   = 1'b0;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt_q == WCW'(RD_LAT - 1)) begin
          state_d    = HOLD;
          tx_valid_d = 1'b1;
          tx_data_d  = fifo_rdata;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      HOLD: begin
        if (tx_ready) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrb_q      <= 1'b1;
      rdb_q      <= 1'b1;
      wdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      wrb_q      <= wrb_d;
      rdb_q      <= rdb_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      level_q    <= level_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(inc && level_q == CW'(DEPTH - 1)));
  a_no_underflow: assert property (@(posedge CLK) disable iff (RESET)
    !(dec && level_q == '0));

`ifdef UART_FIFO_SCHED_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = level_q >= thresh;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign irq           = 1'b0;
`endif

  assign req0_ready = (gnt == GNT_REQ0) && !RESET;
  assign req1_ready = (gnt == GNT_REQ1) && !RESET;
  assign WRB        = wrb_q;
  assign RDB        = rdb_q;
  assign fifo_wdata = wdata_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign level      = level_q;

endmodule

// File: tb/tb_uart_fifo_sched.sv
// tb/tb_uart_fifo_sched.sv - directed vector bench for uart_fifo_sched (irq checks follow UART_FIFO_SCHED_IRQ_EN)
`timescale 1ns/1ps
module tb_uart_fifo_sched;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       WRB, RDB;
  logic [7:0] fifo_wdata;
  logic [7:0] fifo_rdata;
  logic [7:0] level;
  logic [7:0] thresh = 8'd4;
  logic       irq;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] wlog[$];
  logic [7:0] txlog[$];
  logic [7:0] rd_s1;
  int         fifo_err = 0;
  int         irq_err = 0;
  logic [7:0] prev_level = 8'h00;
  logic       prev_rst = 1'b1;

  typedef struct {
    logic       rst, v0, v1, txr;
    logic [7:0] d0, d1;
    logic       r0, r1, wrb, rdb;
    logic [7:0] wd, lvl;
    logic       txv;
    logic [7:0] txd;
  } vec_t;

  vec_t       vec[12];
  int         alt_err, grants, err, n, first, nvalid;
  logic       g0, g1;
  logic [7:0] data, e;
  logic [15:0] pair;

  always #5 CLK = ~CLK;

  uart_fifo_sched dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .WRB        (WRB),
    .RDB        (RDB),
    .fifo_wdata (fifo_wdata),
    .fifo_rdata (fifo_rdata),
    .level      (level),
    .thresh     (thresh),
    .irq        (irq)
  );

  // FIFO model: data valid RD_LAT=2 cycles after the RDB-low cycle
  always @(posedge CLK) begin
    if (RESET) begin
      fifo_q.delete();
      rd_s1      <= 8'h00;
      fifo_rdata <= 8'h00;
    end else begin
      if (!RDB) begin
        if (fifo_q.size() == 0) fifo_err <= fifo_err + 1;
        else rd_s1 <= fifo_q.pop_front();
      end
      fifo_rdata <= rd_s1;
      if (!WRB) begin
        fifo_q.push_back(fifo_wdata);
        wlog.push_back(fifo_wdata);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET && tx_valid && tx_ready) txlog.push_back(tx_data);
  end

  always @(negedge CLK) begin
    if (!RESET && !prev_rst) begin
`ifdef UART_FIFO_SCHED_IRQ_EN
      if (irq !== (prev_level >= thresh)) irq_err <= irq_err + 1;
`else
      if (irq !== 1'b0) irq_err <= irq_err + 1;
`endif
    end
    prev_level <= level;
    prev_rst   <= RESET;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tx_ready   = 1'b0;
    repeat (3) cyc();
    RESET = 1'b0;
  endtask

  initial begin
    //          rst   v0    v1    txr   d0     d1     r0    r1    wrb   rdb   wd     lvl    txv   txd
    vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h90, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h90, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
    vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h90, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h91, 1'b1, 1'b0, 1'b0, 1'b1, 8'h90, 8'h01, 1'b0, 8'h00};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h91, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h02, 1'b0, 8'h00};
    vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h92, 1'b1, 1'b0, 1'b0, 1'b1, 8'h91, 8'h02, 1'b0, 8'h00};
    vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h13, 8'h92, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h03, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 8'h93, 1'b0, 1'b0, 1'b0, 1'b1, 8'h92, 8'h04, 1'b1, 8'h10};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1, 8'h92, 8'h05, 1'b1, 8'h10};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1, 8'h92, 8'h05, 1'b0, 8'h10};
    vec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 8'h93, 1'b0, 1'b0, 1'b1, 1'b0, 8'h92, 8'h05, 1'b0, 8'h10};
    vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 8'h93, 1'b0, 1'b0, 1'b1, 1'b1, 8'h92, 8'h04, 1'b0, 8'h10};

    RESET = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 12; i++) begin
      RESET      = vec[i].rst;
      req0_valid = vec[i].v0;
      req1_valid = vec[i].v1;
      tx_ready   = vec[i].txr;
      req0_data  = vec[i].d0;
      req1_data  = vec[i].d1;
      @(negedge CLK);
      check($sformatf("vec%0d {r0,r1,wrb,rdb,wd,lvl,txv,txd}", i),
            32'({req0_ready, req1_ready, WRB, RDB, fifo_wdata, level, tx_valid, tx_data}),
            32'({vec[i].r0, vec[i].r1, vec[i].wrb, vec[i].rdb, vec[i].wd, vec[i].lvl, vec[i].txv, vec[i].txd}));
      cyc();
    end

    // Both producers streaming: strict alternation and interleaved FIFO contents
    do_reset();
    wlog.delete();
    txlog.delete();
    req0_data  = 8'h00;
    req1_data  = 8'h80;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tx_ready   = 1'b1;
    alt_err    = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 !== ((i % 2) == 0) || g1 !== ((i % 2) == 1)) alt_err++;
      cyc();
      if (g0) req0_data++;
      if (g1) req1_data++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (txlog.size() < 32 && n < 400) begin
      cyc();
      n++;
    end
    repeat (4) cyc();
    check("alt_grants", 32'(alt_err), 32'd0);
    check("alt_wlog_size", 32'(wlog.size()), 32'd32);
    check("alt_drain_size", 32'(txlog.size()), 32'd32);
    err = 0;
    for (int k = 0; k < 32; k++) begin
      e = 8'(k / 2) | (((k % 2) == 1) ? 8'h80 : 8'h00);
      if (k >= wlog.size() || wlog[k] !== e) err++;
      if (k >= txlog.size() || txlog[k] !== e) err++;
    end
    check("alt_order", 32'(err), 32'd0);
    check("alt_level_empty", 32'(level), 32'd0);

    // Fill to capacity with the consumer stalled
    do_reset();
    req0_data  = 8'h00;
    req0_valid = 1'b1;
    tx_ready   = 1'b0;
    grants     = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      g0 = req0_ready;
      if (g0) grants++;
      cyc();
      if (g0) req0_data++;
    end
    check("fill_grants", 32'(grants), 32'd256);
    check("fill_level", 32'(level), 32'd255);
    req1_valid = 1'b1;
    err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (req0_ready || req1_ready || !WRB) err++;
      cyc();
    end
    check("full_blocks_writes", 32'(err), 32'd0);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    grants   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req0_ready || req1_ready) grants++;
      cyc();
    end
    check("one_more_grant", 32'(grants), 32'd1);
    check("refill_level", 32'(level), 32'd255);

    // Single byte through an empty FIFO, reset taken mid-operation
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    tx_ready   = 1'b1;
    @(negedge CLK);
    check("post_reset_txvalid", 32'(tx_valid), 32'd0);
    check("post_reset_level", 32'(level), 32'd0);
    check("single_grant", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    first  = -1;
    nvalid = 0;
    data   = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (tx_valid) begin
        nvalid++;
        if (first < 0) begin
          first = k;
          data  = tx_data;
        end
      end
      cyc();
    end
    check("single_latency", 32'(first), 32'd6);
    check("single_data", 32'(data), 32'hA5);
    check("single_pulse", 32'(nvalid), 32'd1);
    check("single_level", 32'(level), 32'd0);

    // Stalled consumer in HOLD
    do_reset();
    txlog.delete();
    tx_ready   = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    cyc();
    req0_data = 8'h3D;
    cyc();
    req0_valid = 1'b0;
    n = 0;
    while (!tx_valid && n < 20) begin
      cyc();
      n++;
    end
    check("hold_reached", 32'(tx_valid), 32'd1);
    err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!tx_valid || tx_data !== 8'h3C || !RDB || level !== 8'd1) err++;
      cyc();
    end
    check("hold_stall", 32'(err), 32'd0);
    tx_ready = 1'b1;
    repeat (15) cyc();
    check("hold_tx_count", 32'(txlog.size()), 32'd2);
    pair = (txlog.size() >= 2) ? {txlog[0], txlog[1]} : 16'hDEAD;
    check("hold_tx_order", 32'(pair), 32'h3C3D);

    check("fifo_model_underflow", 32'(fifo_err), 32'd0);
    check("irq_behaviour", 32'(irq_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
